// File: rtl/multicycle_alu_pkg.sv
// Shared operation codes and FSM encodings for the multicycle ALU and the ALU control decoder.
package multicycle_alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SRL) || (op == OP_SLL);
    endfunction

endpackage

// File: rtl/multicycle_alu_logic_unit.sv
// Single-cycle combinational AND/OR/NOR/ADD/SUB block; flags any other code as unsupported.
module alu_logic_unit
    import multicycle_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  supported
);

    // Operation select; arithmetic wraps modulo 2^DATA_WIDTH
    always_comb begin
        result    = {DATA_WIDTH{1'b0}};
        supported = 1'b1;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOR:  result = ~(a | b);
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            default: begin
                result    = {DATA_WIDTH{1'b0}};
                supported = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: logic ops take one execute cycle, shifts iterate one bit per cycle.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            ALUOperation,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [4:0]            shamt,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  Error
);

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [3:0]            op_r;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] b_r;
    logic [DATA_WIDTH-1:0] work_r;
    logic [4:0]            cnt_r;
    logic                  err_r;
    logic [DATA_WIDTH-1:0] alu_result_r;
    logic                  zero_r;
    logic                  error_r;
    logic                  done_r;
    logic                  busy_r;
    logic [DATA_WIDTH-1:0] logic_res_s;
    logic                  logic_ok_s;

    alu_logic_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_logic (
        .op        (op_r),
        .a         (a_r),
        .b         (b_r),
        .result    (logic_res_s),
        .supported (logic_ok_s)
    );

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = is_shift_op(ALUOperation) ? ST_SHIFT : ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_DONE;
            ST_SHIFT: begin
                if (cnt_r == 5'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, operand capture, shift iteration and result publication
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            op_r         <= 4'd0;
            a_r          <= {DATA_WIDTH{1'b0}};
            b_r          <= {DATA_WIDTH{1'b0}};
            work_r       <= {DATA_WIDTH{1'b0}};
            cnt_r        <= 5'd0;
            err_r        <= 1'b0;
            alu_result_r <= {DATA_WIDTH{1'b0}};
            zero_r       <= 1'b0;
            error_r      <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r   <= ALUOperation;
                        a_r    <= A;
                        b_r    <= B;
                        work_r <= B;
                        cnt_r  <= is_shift_op(ALUOperation) ? shamt : 5'd0;
                        err_r  <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    work_r <= logic_ok_s ? logic_res_s : {DATA_WIDTH{1'b0}};
                    err_r  <= ~logic_ok_s;
                end
                ST_SHIFT: begin
                    // Zero-filled single-bit step while the counter runs down
                    if (cnt_r != 5'd0) begin
                        work_r <= (op_r == OP_SLL) ? {work_r[DATA_WIDTH-2:0], 1'b0}
                                                   : {1'b0, work_r[DATA_WIDTH-1:1]};
                        cnt_r  <= cnt_r - 5'd1;
                    end
                end
                ST_DONE: begin
                    alu_result_r <= work_r;
                    zero_r       <= (work_r == {DATA_WIDTH{1'b0}});
                    error_r      <= err_r;
                    done_r       <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign ALUResult = alu_result_r;
    assign Zero      = zero_r;
    assign Error     = error_r;

endmodule
